// File: rtl/clken_gen_if.sv
// Configuration write port of the clock-enable generator.
// The master drives the write strobe; clken_gen samples it as the slave.
interface clken_gen_if #(
    parameter int CW = 16
);
    logic          cfg_we;
    logic [2:0]    cfg_ch;
    logic          cfg_mode;
    logic [CW-1:0] cfg_val;

    modport master (
        output cfg_we,
        output cfg_ch,
        output cfg_mode,
        output cfg_val
    );

    modport slave (
        input cfg_we,
        input cfg_ch,
        input cfg_mode,
        input cfg_val
    );
endinterface

// File: rtl/clken_gen.sv
// Multi-channel clock-enable generator on the 48 MHz clock.
// Each channel is an integer divider or a fractional phase accumulator, with edge enables.
module clken_gen #(
    parameter int                 NCH    = 4,
    parameter int                 CW     = 16,
    parameter logic [NCH*CW-1:0]  DEFDIV = {16'd16, 16'd8, 16'd4, 16'd2}
) (
    input  logic            clk48M,
    input  logic            reset,
    input  logic [NCH-1:0]  hold,
    input  logic            resync,
    clken_gen_if.slave      cfg,
    output logic [NCH-1:0]  clk_o,
    output logic [NCH-1:0]  ce_r,
    output logic [NCH-1:0]  ce_f
);

    localparam logic [CW-1:0] LP_TWO    = CW'(2);
    localparam logic [CW-1:0] LP_MAXINC = {1'b1, {(CW-1){1'b0}}};

    function automatic logic [CW-1:0] effDiv(input logic [CW-1:0] v);
        return (v < LP_TWO) ? LP_TWO : v;
    endfunction

    function automatic logic [CW-1:0] effInc(input logic [CW-1:0] v);
        return (v > LP_MAXINC) ? LP_MAXINC : v;
    endfunction

    function automatic logic [CW-1:0] advance(input logic m, input logic [CW-1:0] v,
                                              input logic [CW-1:0] c);
        if (m) begin
            return c + effInc(v);
        end
        return (c >= effDiv(v) - CW'(1)) ? '0 : c + CW'(1);
    endfunction

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic          r_mode;
        logic [CW-1:0] r_val;
        logic [CW-1:0] r_cnt;
        logic          r_prevMsb;

        logic          w_sel;
        logic [CW-1:0] w_half;
        logic          w_lvl;
        logic          w_rise;
        logic          w_fall;
        logic          w_nextMode;
        logic [CW-1:0] w_nextVal;
        logic [CW-1:0] w_nextCnt;
        logic          w_nextPrev;

        assign w_sel  = cfg.cfg_we && ({1'b0, cfg.cfg_ch} == 4'(i));
        assign w_half = effDiv(r_val) >> 1;

        always_comb begin
            w_lvl  = 1'b0;
            w_rise = 1'b0;
            w_fall = 1'b0;
            if (r_mode) begin
                w_lvl  = r_cnt[CW-1];
                w_rise = r_cnt[CW-1] & ~r_prevMsb;
                w_fall = ~r_cnt[CW-1] & r_prevMsb;
            end else begin
                w_lvl  = (r_cnt >= w_half);
                w_rise = (r_cnt == w_half);
                w_fall = (r_cnt == '0);
            end
        end

        // Outputs are forced low during reset, since cnt = 0 would otherwise decode as ce_f.
        assign clk_o[i] = w_lvl & ~reset;
        assign ce_r[i]  = w_rise & ~hold[i] & ~reset;
        assign ce_f[i]  = w_fall & ~hold[i] & ~reset;

        always_comb begin
            w_nextMode = r_mode;
            w_nextVal  = r_val;
            w_nextCnt  = r_cnt;
            w_nextPrev = r_prevMsb;
            if (w_sel) begin
                w_nextMode = cfg.cfg_mode;
                w_nextVal  = cfg.cfg_val;
            end
            if (!hold[i]) begin
                w_nextCnt  = advance(w_nextMode, w_nextVal, r_cnt);
                w_nextPrev = r_cnt[CW-1];
            end
            if (w_sel) begin
                if (cfg.cfg_mode != r_mode) begin
                    w_nextCnt  = '0;
                    w_nextPrev = 1'b0;
                end else if (!cfg.cfg_mode && (r_cnt >= effDiv(cfg.cfg_val))) begin
                    w_nextCnt = '0;
                end
            end
            if (resync) begin
                w_nextCnt  = '0;
                w_nextPrev = 1'b0;
            end
        end

        always_ff @(posedge clk48M or posedge reset) begin
            if (reset) begin
                r_mode    <= 1'b0;
                r_val     <= DEFDIV[i*CW +: CW];
                r_cnt     <= '0;
                r_prevMsb <= 1'b0;
            end else begin
                r_mode    <= w_nextMode;
                r_val     <= w_nextVal;
                r_cnt     <= w_nextCnt;
                r_prevMsb <= w_nextPrev;
            end
        end
    end

endmodule

// File: tb/tb_clken_gen.sv
// Scoreboard bench for clken_gen: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them and tallies channel 2 pulses.
module tb_clken_gen;

    logic       clk48M = 1'b0;
    logic       reset  = 1'b1;
    logic [3:0] hold   = 4'b0000;
    logic       resync = 1'b0;
    logic [3:0] clk_o;
    logic [3:0] ce_r;
    logic [3:0] ce_f;

    clken_gen_if #(.CW(16)) cfgIf ();

    clken_gen #(.NCH(4), .CW(16)) dut (
        .clk48M (clk48M),
        .reset  (reset),
        .hold   (hold),
        .resync (resync),
        .cfg    (cfgIf),
        .clk_o  (clk_o),
        .ce_r   (ce_r),
        .ce_f   (ce_f)
    );

    always #5 clk48M = ~clk48M;

    typedef struct {
        int         kind;
        string      tag;
        logic [3:0] mask;
        logic [3:0] eClk;
        logic [3:0] eR;
        logic [3:0] eF;
        int         eCntR;
        int         eCntF;
    } expT;

    expT sbQ[$];
    int  errors = 0;
    int  checks = 0;
    int  cntR   = 0;
    int  cntF   = 0;

    function automatic logic [2:0] intExp(input int cnt, input int n);
        return {cnt >= n / 2, cnt == n / 2, cnt == 0};
    endfunction

    task automatic applyStimulus(input string tag, input logic rst, input logic [3:0] h,
                                 input logic rs, input logic we, input logic [2:0] ch,
                                 input logic md, input logic [15:0] val,
                                 input logic [3:0] mask, input logic [3:0] eClk,
                                 input logic [3:0] eR, input logic [3:0] eF);
        expT e;
        @(posedge clk48M);
        #1;
        reset           = rst;
        hold            = h;
        resync          = rs;
        cfgIf.cfg_we    = we;
        cfgIf.cfg_ch    = ch;
        cfgIf.cfg_mode  = md;
        cfgIf.cfg_val   = val;
        if (mask != 4'b0000) begin
            e.kind  = 0;
            e.tag   = tag;
            e.mask  = mask;
            e.eClk  = eClk;
            e.eR    = eR;
            e.eF    = eF;
            e.eCntR = 0;
            e.eCntF = 0;
            sbQ.push_back(e);
        end
    endtask

    task automatic pushMark(input int kind, input string tag, input int eCntR, input int eCntF);
        expT e;
        e.kind  = kind;
        e.tag   = tag;
        e.mask  = 4'b0000;
        e.eClk  = 4'b0000;
        e.eR    = 4'b0000;
        e.eF    = 4'b0000;
        e.eCntR = eCntR;
        e.eCntF = eCntF;
        sbQ.push_back(e);
    endtask

    task automatic checkOutput(input expT e, input logic [3:0] aClk, input logic [3:0] aR,
                               input logic [3:0] aF);
        if (e.kind == 0) begin
            checks++;
            if (((aClk & e.mask) !== (e.eClk & e.mask)) ||
                ((aR & e.mask) !== (e.eR & e.mask)) ||
                ((aF & e.mask) !== (e.eF & e.mask))) begin
                errors++;
                $display("[TB] FAIL %s: got clk_o=%b ce_r=%b ce_f=%b, want clk_o=%b ce_r=%b ce_f=%b (mask %b)",
                         e.tag, aClk & e.mask, aR & e.mask, aF & e.mask,
                         e.eClk & e.mask, e.eR & e.mask, e.eF & e.mask, e.mask);
            end
        end else if (e.kind == 1) begin
            cntR = 0;
            cntF = 0;
        end else begin
            checks++;
            if ((cntR != e.eCntR) || (cntF != e.eCntF)) begin
                errors++;
                $display("[TB] FAIL %s: got rises=%0d falls=%0d, want rises=%0d falls=%0d",
                         e.tag, cntR, cntF, e.eCntR, e.eCntF);
            end
        end
    endtask

    // Monitor: consume every expectation queued for this cycle, then tally ch2 pulses.
    initial begin
        expT e;
        forever begin
            @(negedge clk48M);
            while (sbQ.size() > 0) begin
                e = sbQ.pop_front();
                checkOutput(e, clk_o, ce_r, ce_f);
            end
            cntR += int'(ce_r[2]);
            cntF += int'(ce_f[2]);
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] eC;
        logic [3:0] eR;
        logic [3:0] eF;
        logic [2:0] x;
        int         k3;
        logic       h3;

        cfgIf.cfg_we   = 1'b0;
        cfgIf.cfg_ch   = 3'd0;
        cfgIf.cfg_mode = 1'b0;
        cfgIf.cfg_val  = 16'd0;

        for (int n = 0; n < 3; n++)
            applyStimulus("reset", 1'b1, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 16'd0,
                          4'hF, 4'h0, 4'h0, 4'h0);

        // Defaults: channel k divides by 2^(k+1); a write to channel 4 must be ignored.
        for (int c = 0; c < 32; c++) begin
            for (int k = 0; k < 4; k++) begin
                x = intExp(c % (2 << k), 2 << k);
                eC[k] = x[2];
                eR[k] = x[1];
                eF[k] = x[0];
            end
            applyStimulus("default", 1'b0, 4'h0, 1'b0, c == 5, 3'd4, 1'b1, 16'd3,
                          4'hF, eC, eR, eF);
        end

        applyStimulus("wrDiv5", 1'b0, 4'h0, 1'b0, 1'b1, 3'd1, 1'b0, 16'd5,
                      4'hF, 4'h0, 4'h0, 4'hF);
        for (int d = 1; d <= 10; d++) begin
            x = intExp(d % 5, 5);
            applyStimulus("div5", 1'b0, 4'h0, 1'b0, d == 10, 3'd1, 1'b0, 16'd0,
                          4'b0010, {2'b00, x[2], 1'b0}, {2'b00, x[1], 1'b0}, {2'b00, x[0], 1'b0});
        end
        for (int e = 1; e <= 6; e++) begin
            x = intExp(e % 2, 2);
            applyStimulus("div0", 1'b0, 4'h0, 1'b0, e == 6, 3'd1, 1'b0, 16'd1,
                          4'b0010, {2'b00, x[2], 1'b0}, {2'b00, x[1], 1'b0}, {2'b00, x[0], 1'b0});
        end
        for (int f = 1; f <= 6; f++) begin
            x = intExp(f % 2, 2);
            applyStimulus("div1", 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 16'd0,
                          4'b0010, {2'b00, x[2], 1'b0}, {2'b00, x[1], 1'b0}, {2'b00, x[0], 1'b0});
        end

        applyStimulus("resyncReq", 1'b0, 4'h0, 1'b1, 1'b1, 3'd0, 1'b0, 16'd6,
                      4'h0, 4'h0, 4'h0, 4'h0);

        // After resync: ch0 N=6, ch1 N=2, ch2 N=8, ch3 N=16 held at cnt 5 for g=5..14.
        for (int g = 0; g <= 20; g++) begin
            h3 = (g >= 5) && (g <= 14);
            k3 = (g < 5) ? g : ((g <= 14) ? 5 : g - 10);
            x = intExp(g % 6, 6);
            eC[0] = x[2]; eR[0] = x[1]; eF[0] = x[0];
            x = intExp(g % 2, 2);
            eC[1] = x[2]; eR[1] = x[1]; eF[1] = x[0];
            x = intExp(g % 8, 8);
            eC[2] = x[2]; eR[2] = x[1]; eF[2] = x[0];
            x = intExp(k3, 16);
            eC[3] = x[2]; eR[3] = x[1] & ~h3; eF[3] = x[0] & ~h3;
            applyStimulus((g < 5) ? "resync" : ((g <= 14) ? "hold" : "release"),
                          1'b0, {h3, 3'b000}, 1'b0, 1'b0, 3'd0, 1'b0, 16'd0,
                          4'hF, eC, eR, eF);
        end

        applyStimulus("wrDiv8", 1'b0, 4'h0, 1'b0, 1'b1, 3'd1, 1'b0, 16'd8,
                      4'b0010, 4'b0010, 4'b0010, 4'b0000);
        for (int h = 1; h <= 6; h++) begin
            x = intExp(h + 1, 8);
            applyStimulus("div8", 1'b0, 4'h0, 1'b0, h == 6, 3'd1, 1'b0, 16'd4,
                          4'b0010, {2'b00, x[2], 1'b0}, {2'b00, x[1], 1'b0}, {2'b00, x[0], 1'b0});
        end
        for (int p = 0; p <= 4; p++) begin
            x = intExp(p % 4, 4);
            applyStimulus("div4", 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 16'd0,
                          4'b0010, {2'b00, x[2], 1'b0}, {2'b00, x[1], 1'b0}, {2'b00, x[0], 1'b0});
        end

        // Reset pulse that spans no rising edge: state must still clear.
        applyStimulus("asyncRst", 1'b1, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 16'd0,
                      4'hF, 4'h0, 4'h0, 4'h0);
        @(negedge clk48M);
        #2;
        reset = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            for (int k = 0; k < 4; k++) begin
                x = intExp(c % (2 << k), 2 << k);
                eC[k] = x[2];
                eR[k] = x[1];
                eF[k] = x[0];
            end
            applyStimulus("afterRst", 1'b0, 4'h0, 1'b0, c == 9, 3'd2, 1'b1, 16'h1234,
                          4'hF, eC, eR, eF);
        end

        // Fractional ch2, INC 0x1234: cnt crosses 0x8000 first at q=8.
        for (int q = 0; q <= 65537; q++) begin
            applyStimulus("frac", 1'b0, 4'h0, 1'b0, q == 65537, 3'd2, 1'b1, 16'hFFFF,
                          (q <= 9) ? 4'b0100 : 4'b0000,
                          {1'b0, q >= 8, 2'b00}, {1'b0, q == 8, 2'b00}, 4'h0);
            if (q == 1)
                pushMark(1, "fracClear", 0, 0);
            if (q == 65537)
                pushMark(2, "fracCount", 16'h1234, 16'h1234);
        end
        for (int r = 1; r <= 6; r++) begin
            applyStimulus("incClamp", 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 16'd0,
                          4'b0100, {1'b0, r % 2 == 1, 2'b00}, {1'b0, r % 2 == 1, 2'b00},
                          {1'b0, r % 2 == 0, 2'b00});
        end

        repeat (3) @(posedge clk48M);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
